dispatch_arbiter_rr: RTL

Parametrised, registered successor to the single-cycle dispatch arbiter. It takes one dispatched uop per cycle and steers it to one of `NUM_OUT` reservation-station ports, chosen by a per-port fuType mask. When several ports can take the uop, a round-robin pointer picks one. Each port has a one-entry output slice that a redirect can flush.

---
 rtl/dispatch_pkg.sv | 30 +++
 rtl/dispatch_arbiter_rr_if.sv | 71 +++++++
 rtl/dispatch_slot.sv | 45 ++++
 rtl/dispatch_arbiter_rr.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/dispatch_pkg.sv
// Shared types and helpers for the round-robin dispatch arbiter.
// robIdx ordering and default per-port fuType masks live here.
package dispatch_pkg;

  localparam int ROB_MAX_W = 16;

  typedef struct packed {
    logic                 flag;
    logic [ROB_MAX_W-1:0] value;
  } rob_idx_t;

  localparam int FU_JMP    = 0;
  localparam int FU_MUL_LO = 4;
  localparam int FU_ALU    = 6;
  localparam int FU_MUL_HI = 7;

  localparam logic [15:0] MASK_ALU = 16'h0040;
  localparam logic [15:0] MASK_MUL = 16'h00F0;

  localparam logic [31:0] DEFAULT_MASK =
    {MASK_MUL, MASK_ALU};

  function automatic logic is_after(
    input rob_idx_t a,
    input rob_idx_t b
  );
    return (a.flag ^ b.flag) ^ (a.value > b.value);
  endfunction

endpackage

// File: rtl/dispatch_arbiter_rr_if.sv
// Dispatch input, redirect and per-port output bundle.
// slave = arbiter side, master = producer/consumer side.
interface dispatch_arbiter_rr_if #(
  parameter int NUM_OUT   = 2,
  parameter int FU_W      = 4,
  parameter int ROB_VAL_W = 5,
  parameter int PAYLOAD_W = 128
);

  logic                 io_in_valid;
  logic                 io_in_ready;
  logic [FU_W-1:0]      io_in_bits_fuType;
  logic                 io_in_bits_robIdx_flag;
  logic [ROB_VAL_W-1:0] io_in_bits_robIdx_value;
  logic [PAYLOAD_W-1:0] io_in_bits_payload;

  logic                 io_redirect_valid;
  logic                 io_redirect_bits_robIdx_flag;
  logic [ROB_VAL_W-1:0] io_redirect_bits_robIdx_value;
  logic                 io_redirect_bits_level;

  logic [NUM_OUT-1:0]           io_out_valid;
  logic [NUM_OUT-1:0]           io_out_ready;
  logic [NUM_OUT*FU_W-1:0]      io_out_bits_fuType;
  logic [NUM_OUT-1:0]           io_out_bits_robIdx_flag;
  logic [NUM_OUT*ROB_VAL_W-1:0] io_out_bits_robIdx_value;
  logic [NUM_OUT*PAYLOAD_W-1:0] io_out_bits_payload;

  logic io_unroutable;

  modport slave (
    input  io_in_valid,
    output io_in_ready,
    input  io_in_bits_fuType,
    input  io_in_bits_robIdx_flag,
    input  io_in_bits_robIdx_value,
    input  io_in_bits_payload,
    input  io_redirect_valid,
    input  io_redirect_bits_robIdx_flag,
    input  io_redirect_bits_robIdx_value,
    input  io_redirect_bits_level,
    output io_out_valid,
    input  io_out_ready,
    output io_out_bits_fuType,
    output io_out_bits_robIdx_flag,
    output io_out_bits_robIdx_value,
    output io_out_bits_payload,
    output io_unroutable
  );

  modport master (
    output io_in_valid,
    input  io_in_ready,
    output io_in_bits_fuType,
    output io_in_bits_robIdx_flag,
    output io_in_bits_robIdx_value,
    output io_in_bits_payload,
    output io_redirect_valid,
    output io_redirect_bits_robIdx_flag,
    output io_redirect_bits_robIdx_value,
    output io_redirect_bits_level,
    input  io_out_valid,
    output io_out_ready,
    input  io_out_bits_fuType,
    input  io_out_bits_robIdx_flag,
    input  io_out_bits_robIdx_value,
    input  io_out_bits_payload,
    input  io_unroutable
  );

endinterface

// File: rtl/dispatch_slot.sv
// One-entry output register slice with load, drain and kill.
// Kill wins over load and drain; data regs are not reset.
module dispatch_slot #(
  parameter int FU_W      = 4,
  parameter int ROB_VAL_W = 5,
  parameter int PAYLOAD_W = 128
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 drain,
  input  logic                 kill,
  input  logic [FU_W-1:0]      in_fu,
  input  logic                 in_flag,
  input  logic [ROB_VAL_W-1:0] in_value,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 valid,
  output logic [FU_W-1:0]      fu,
  output logic                 flag,
  output logic [ROB_VAL_W-1:0] value,
  output logic [PAYLOAD_W-1:0] payload
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid <= 1'b0;
    end else if (kill) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (load) begin
      fu      <= in_fu;
      flag    <= in_flag;
      value   <= in_value;
      payload <= in_payload;
    end
  end

endmodule

// File: rtl/dispatch_arbiter_rr.sv
// Registered dispatch arbiter: fuType-masked steering to NUM_OUT
// one-entry slices with round-robin choice and redirect flush.
module dispatch_arbiter_rr
  import dispatch_pkg::*;
#(
  parameter int NUM_OUT   = 2,
  parameter int FU_W      = 4,
  parameter int ROB_VAL_W = 5,
  parameter int PAYLOAD_W = 128,
  parameter logic [NUM_OUT*(2**FU_W)-1:0] OUT_FU_MASK =
    DEFAULT_MASK
) (
  input logic clock,
  input logic reset,
  dispatch_arbiter_rr_if.slave bus
);

  localparam int FW    = 2**FU_W;
  localparam int PTR_W =
    (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   rr_nxt;
  logic [PTR_W-1:0]   chosen;
  logic               found;
  logic               fire;
  logic               unroutable;

  logic [NUM_OUT-1:0] slot_valid;
  logic [NUM_OUT-1:0] elig;
  logic [NUM_OUT-1:0] take;
  logic [NUM_OUT-1:0] load;
  logic [NUM_OUT-1:0] kill;

  logic [2*NUM_OUT-1:0] rot;

  rob_idx_t redir;

  assign redir = '{
    flag:  bus.io_redirect_bits_robIdx_flag,
    value: ROB_MAX_W'(bus.io_redirect_bits_robIdx_value)
  };

  // Rotate the candidate set so bit 0 is the rr_ptr port.
  assign rot = {take, take} >> rr_ptr;

  always_comb begin
    logic [PTR_W:0] sum;
    found  = 1'b0;
    chosen = '0;
    sum    = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, rr_ptr} + (PTR_W+1)'(k);
        if (sum >= (PTR_W+1)'(NUM_OUT)) begin
          sum = sum - (PTR_W+1)'(NUM_OUT);
        end
        chosen = sum[PTR_W-1:0];
      end
    end
  end

  assign bus.io_in_ready = !bus.io_redirect_valid &&
                           (found || !(|elig));
  assign fire = bus.io_in_valid && bus.io_in_ready;

  always_comb begin
    rr_nxt = rr_ptr;
    if (fire && found) begin
      if (chosen == PTR_W'(NUM_OUT-1)) begin
        rr_nxt = '0;
      end else begin
        rr_nxt = chosen + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_ptr     <= '0;
      unroutable <= 1'b0;
    end else begin
      rr_ptr <= rr_nxt;
      if (fire && !(|elig)) begin
        unroutable <= 1'b1;
      end
    end
  end

  assign bus.io_unroutable = unroutable;
  assign bus.io_out_valid  = slot_valid;

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_port
    logic [FW-1:0]        mask;
    logic [FU_W-1:0]      fu_q;
    logic                 flag_q;
    logic [ROB_VAL_W-1:0] value_q;
    logic [PAYLOAD_W-1:0] payload_q;
    rob_idx_t             slot_rob;

    assign mask    = OUT_FU_MASK[i*FW +: FW];
    assign elig[i] = mask[bus.io_in_bits_fuType];
    assign take[i] = elig[i] &&
                     (!slot_valid[i] || bus.io_out_ready[i]);
    assign load[i] = fire && found &&
                     (chosen == PTR_W'(i));

    assign slot_rob = '{
      flag:  flag_q,
      value: ROB_MAX_W'(value_q)
    };
    assign kill[i] = bus.io_redirect_valid &&
      (is_after(slot_rob, redir) ||
       (bus.io_redirect_bits_level && slot_rob == redir));

    dispatch_slot #(
      .FU_W      (FU_W),
      .ROB_VAL_W (ROB_VAL_W),
      .PAYLOAD_W (PAYLOAD_W)
    ) u_slot (
      .clock      (clock),
      .reset      (reset),
      .load       (load[i]),
      .drain      (bus.io_out_ready[i]),
      .kill       (kill[i]),
      .in_fu      (bus.io_in_bits_fuType),
      .in_flag    (bus.io_in_bits_robIdx_flag),
      .in_value   (bus.io_in_bits_robIdx_value),
      .in_payload (bus.io_in_bits_payload),
      .valid      (slot_valid[i]),
      .fu         (fu_q),
      .flag       (flag_q),
      .value      (value_q),
      .payload    (payload_q)
    );

    assign bus.io_out_bits_fuType[i*FU_W +: FU_W] = fu_q;
    assign bus.io_out_bits_robIdx_flag[i] = flag_q;
    assign bus.io_out_bits_robIdx_value[i*ROB_VAL_W +: ROB_VAL_W] =
      value_q;
    assign bus.io_out_bits_payload[i*PAYLOAD_W +: PAYLOAD_W] =
      payload_q;
  end

endmodule
